// File: rtl/set_scan_ctrl.sv
// Scan sequencer for the LU set-logic unit: walks the grid one point per cycle,
// presents circle coverage of each point to the external LU and counts its hits.
module set_scan_ctrl #(
  parameter int COORD_W  = 4,
  parameter int GRID_MIN = 1,
  parameter int GRID_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [6*COORD_W-1:0]   central,
  input  logic [3*COORD_W-1:0]   radius,
  input  logic [1:0]             mode,
  input  logic                   hit_i,
  output logic [2:0]             covered_o,
  output logic [1:0]             mode_o,
  output logic                   busy,
  output logic                   valid,
  output logic [CNT_W-1:0]       candidate
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int SQ_W = 2*COORD_W + 2;
  localparam logic [COORD_W-1:0] GMIN = COORD_W'(GRID_MIN);
  localparam logic [COORD_W-1:0] GMAX = COORD_W'(GRID_MAX);

  logic [1:0]           state_q, state_d;
  logic [COORD_W-1:0]   x_q, x_d, y_q, y_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cand_q, cand_d;
  logic [1:0]           mode_q, mode_d;
  logic [6*COORD_W-1:0] cen_q, cen_d;
  logic [3*COORD_W-1:0] rad_q, rad_d;
  logic                 in_a, in_b, in_c;

  // Inclusive disc test; differences are signed one bit wider than a coordinate.
  function automatic logic in_circle(input logic [COORD_W-1:0] px, py, cx, cy, r);
    logic signed [COORD_W:0] dx, dy;
    logic signed [SQ_W-1:0]  dxe, dye;
    logic [SQ_W-1:0]         d2, r2;
    dx  = $signed({1'b0, px}) - $signed({1'b0, cx});
    dy  = $signed({1'b0, py}) - $signed({1'b0, cy});
    dxe = SQ_W'(dx);
    dye = SQ_W'(dy);
    d2  = $unsigned(dxe * dxe) + $unsigned(dye * dye);
    r2  = SQ_W'(r) * SQ_W'(r);
    return d2 <= r2;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic h);
    return (h && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
  endfunction

  assign in_a = in_circle(x_q, y_q, cen_q[6*COORD_W-1 -: COORD_W], cen_q[5*COORD_W-1 -: COORD_W],
                          rad_q[3*COORD_W-1 -: COORD_W]);
  assign in_b = in_circle(x_q, y_q, cen_q[4*COORD_W-1 -: COORD_W], cen_q[3*COORD_W-1 -: COORD_W],
                          rad_q[2*COORD_W-1 -: COORD_W]);
  assign in_c = in_circle(x_q, y_q, cen_q[2*COORD_W-1 -: COORD_W], cen_q[COORD_W-1 -: COORD_W],
                          rad_q[COORD_W-1 -: COORD_W]);

  assign covered_o = (state_q == SCAN) ? {in_a, in_b, in_c} : 3'b000;
  assign mode_o    = mode_q;
  assign busy      = (state_q != IDLE);
  assign valid     = (state_q == DONE);
  assign candidate = cand_q;

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    mode_d  = mode_q;
    cen_d   = cen_q;
    rad_d   = rad_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          cen_d   = central;
          rad_d   = radius;
          mode_d  = mode;
          x_d     = GMIN;
          y_d     = GMIN;
          cnt_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        cnt_d = sat_inc(cnt_q, hit_i);
        if (x_q == GMAX) begin
          x_d = GMIN;
          if (y_q == GMAX) begin
            // Last point's hit is folded in so the result is ready during DONE.
            cand_d  = cnt_d;
            state_d = DONE;
          end else begin
            y_d = y_q + COORD_W'(1);
          end
        end else begin
          x_d = x_q + COORD_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      cnt_q   <= '0;
      cand_q  <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      mode_q  <= mode_d;
    end
  end

  // Circle descriptors are only observed through covered_o, which is gated by state.
  always_ff @(posedge clk) begin
    cen_q <= cen_d;
    rad_q <= rad_d;
  end

endmodule
